// File: rtl/v_chunk_tx.sv
// v_chunk_tx: transmit-side consumer of the virtual-peripheral chunk
// interface. Arbitrates round-robin between two chunk sources (A, B),
// serialises the granted chunk as a 4-byte frame
// (SYNC, type, payload, csum) over a byte-wide valid/ready TX port,
// and pulses the granted source's done for one cycle after the frame.
module v_chunk_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'h7E
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       a_should_update,
  input  logic [7:0] a_chunk_type,
  input  logic [7:0] a_chunk_bytes,
  output logic       a_done,
  input  logic       b_should_update,
  input  logic [7:0] b_chunk_type,
  input  logic [7:0] b_chunk_bytes,
  output logic       b_done,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND_SYNC    = 3'd1,
    SEND_TYPE    = 3'd2,
    SEND_PAYLOAD = 3'd3,
    SEND_CSUM    = 3'd4,
    ACK          = 3'd5
  } state_t;

  // Frame checksum covers the sync byte too, so a receiver can XOR all four bytes to zero.
  function automatic logic [7:0] frame_csum(input logic [7:0] typ, input logic [7:0] pay);
    frame_csum = typ ^ pay ^ SYNC_BYTE;
  endfunction

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;   // 1'b0 = A, 1'b1 = B
  logic [7:0] type_q, type_d;
  logic [7:0] payload_q, payload_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       a_done_q, a_done_d;
  logic       b_done_q, b_done_d;
  logic       xfer_s;
  logic       grant_b_s;
  logic [7:0] sel_type_s;
  logic [7:0] sel_payload_s;

  assign xfer_s = tx_valid_q & tx_ready;

  // B wins when it is the only requester, or on a tie when A was granted last.
  assign grant_b_s     = b_should_update & (~a_should_update | ~last_grant_q);
  assign sel_type_s    = grant_b_s ? b_chunk_type  : a_chunk_type;
  assign sel_payload_s = grant_b_s ? b_chunk_bytes : a_chunk_bytes;

  // Next-state and next-output logic; every register holds unless a step below moves it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    type_d       = type_q;
    payload_d    = payload_q;
    csum_d       = csum_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    a_done_d     = 1'b0;
    b_done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_should_update || b_should_update) begin
          type_d       = sel_type_s;
          payload_d    = sel_payload_s;
          csum_d       = frame_csum(sel_type_s, sel_payload_s);
          last_grant_d = grant_b_s;
          tx_data_d    = SYNC_BYTE;
          tx_valid_d   = 1'b1;
          state_d      = SEND_SYNC;
        end else begin
          tx_valid_d   = 1'b0;
        end
      end
      SEND_SYNC: begin
        if (xfer_s) begin
          tx_data_d = type_q;
          state_d   = SEND_TYPE;
        end else begin
          state_d   = SEND_SYNC;
        end
      end
      SEND_TYPE: begin
        if (xfer_s) begin
          tx_data_d = payload_q;
          state_d   = SEND_PAYLOAD;
        end else begin
          state_d   = SEND_TYPE;
        end
      end
      SEND_PAYLOAD: begin
        if (xfer_s) begin
          tx_data_d = csum_q;
          state_d   = SEND_CSUM;
        end else begin
          state_d   = SEND_PAYLOAD;
        end
      end
      SEND_CSUM: begin
        if (xfer_s) begin
          tx_valid_d = 1'b0;
          a_done_d   = ~last_grant_q;
          b_done_d   = last_grant_q;
          state_d    = ACK;
        end else begin
          state_d    = SEND_CSUM;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      type_q       <= 8'h00;
      payload_q    <= 8'h00;
      csum_q       <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      type_q       <= type_d;
      payload_q    <= payload_d;
      csum_q       <= csum_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign a_done   = a_done_q;
  assign b_done   = b_done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_v_chunk_tx.sv
// Scoreboard bench for v_chunk_tx: the stimulus process models two
// chunk sources and predicts frames/acks into queues; an independent
// monitor compares every TX transfer and done pulse against them.
module tb_v_chunk_tx;

  logic       CLK;
  logic       reset;
  logic       a_su, b_su;
  logic [7:0] a_typ, a_pay, b_typ, b_pay;
  logic       a_done, b_done;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy;

  v_chunk_tx #(.SYNC_BYTE(8'h7E)) dut (
    .CLK(CLK), .reset(reset),
    .a_should_update(a_su), .a_chunk_type(a_typ), .a_chunk_bytes(a_pay), .a_done(a_done),
    .b_should_update(b_su), .b_chunk_type(b_typ), .b_chunk_bytes(b_pay), .b_done(b_done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_bytes[$];
  int         exp_src[$];     // 0 = A, 1 = B
  int         model_last = 1; // source granted last; B after reset
  int         rdy_mode   = 0; // 0 high, 1 random, 2 low, 3 pattern 1,0,0,1
  int         cyc_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push_frame(input int src, input logic [7:0] t, input logic [7:0] p);
    exp_bytes.push_back(8'h7E);
    exp_bytes.push_back(t);
    exp_bytes.push_back(p);
    exp_bytes.push_back(t ^ p ^ 8'h7E);
    exp_src.push_back(src);
  endtask

  // One clock step: sources drop their request once acked, ready follows the mode.
  task automatic cyc();
    logic [3:0] pat;
    pat = 4'b1001;
    @(negedge CLK);
    cyc_cnt++;
    if (a_done) a_su = 1'b0;
    if (b_done) b_su = 1'b0;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      2: tx_ready = 1'b0;
      default: tx_ready = pat[3 - (cyc_cnt % 4)];
    endcase
  endtask

  // Raise requests and predict the frame order from round-robin rules.
  task automatic issue(input bit ra, input bit rb,
                       input logic [7:0] ta, input logic [7:0] pa,
                       input logic [7:0] tb_, input logic [7:0] pb);
    cyc();
    if (ra) begin a_su = 1'b1; a_typ = ta;  a_pay = pa; end
    if (rb) begin b_su = 1'b1; b_typ = tb_; b_pay = pb; end
    if (ra && rb) begin
      if (model_last == 1) begin
        push_frame(0, ta, pa); push_frame(1, tb_, pb); model_last = 1;
      end else begin
        push_frame(1, tb_, pb); push_frame(0, ta, pa); model_last = 0;
      end
    end else if (ra) begin
      push_frame(0, ta, pa); model_last = 0;
    end else begin
      push_frame(1, tb_, pb); model_last = 1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((a_su || b_su || busy) && n < 400) begin
      cyc();
      n++;
    end
    if (n >= 400) chk({name, "_timeout"}, 32'(n), 32'd0);
    cyc();
    chk({name, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    chk({name, "_acks_left"}, 32'(exp_src.size()), 32'd0);
  endtask

  // Monitor: samples mid-cycle, compares transfers, stalls and done pulses.
  initial begin
    int         idx;
    bit         done_due, prev_stall, prev_done;
    logic [7:0] prev_data, e;
    idx = 0; done_due = 0; prev_stall = 0; prev_done = 0; prev_data = 8'h00;
    forever begin
      @(negedge CLK);
      #2;
      if (reset) begin
        idx = 0; done_due = 0; prev_stall = 0; prev_done = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(tx_valid), 32'd1);
          chk("stall_data", 32'(tx_data), 32'(prev_data));
        end
        if (a_done && b_done) chk("both_done", 32'd1, 32'd0);
        if (a_done || b_done || done_due) begin
          chk("done_timing", 32'(a_done | b_done), 32'(done_due));
          if (prev_done && (a_done || b_done)) chk("done_width", 32'd2, 32'd1);
          if (a_done || b_done) begin
            if (exp_src.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("done_source", 32'(b_done), 32'(exp_src.pop_front()));
          end
        end
        prev_done = a_done | b_done;
        done_due  = 0;
        if (tx_valid && tx_ready) begin
          if (exp_bytes.size() == 0) begin
            chk("unexpected_byte", 32'(tx_data), 32'h100);
          end else begin
            e = exp_bytes.pop_front();
            chk("tx_byte", 32'(tx_data), 32'(e));
          end
          done_due = (idx == 3);
          idx = (idx + 1) % 4;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  // Stimulus: directed scenarios then randomized traffic.
  initial begin
    int rsel;
    logic [7:0] t0, p0, t1, p1;
    reset = 1'b1; tx_ready = 1'b1;
    a_su = 1'b0; b_su = 1'b0;
    a_typ = 8'h00; a_pay = 8'h00; b_typ = 8'h00; b_pay = 8'h00;
    repeat (3) cyc();
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({a_done, b_done}), 32'd0);
    reset = 1'b0;
    cyc();

    // A only
    rdy_mode = 0;
    issue(1, 0, 8'h02, 8'h5A, 8'h00, 8'h00);
    wait_idle("a_only");

    // Both from a fresh tie, then both again
    issue(1, 1, 8'h02, 8'h11, 8'h03, 8'h22);
    wait_idle("both");
    issue(1, 1, 8'h04, 8'h44, 8'h05, 8'h55);
    wait_idle("both_again");

    // Ready toggling 1,0,0,1
    rdy_mode = 3;
    issue(1, 0, 8'h02, 8'h5A, 8'h00, 8'h00);
    wait_idle("toggle");

    // Snapshot: payload change after grant
    rdy_mode = 0;
    issue(1, 0, 8'h02, 8'h5A, 8'h00, 8'h00);
    cyc();
    chk("snap_busy", 32'(busy), 32'd1);
    a_pay = 8'hFF;
    wait_idle("snap");
    issue(1, 0, 8'h02, 8'hFF, 8'h00, 8'h00);
    wait_idle("snap_ff");

    // Reset while SEND_PAYLOAD is stalled
    issue(1, 0, 8'h02, 8'h5A, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tx_valid && tx_data == 8'h5A) break;
    end
    tx_ready = 1'b0;
    rdy_mode = 2;
    cyc(); cyc();
    cyc();
    reset = 1'b1;
    a_su = 1'b0;
    exp_bytes.delete();
    exp_src.delete();
    model_last = 1;
    cyc();
    reset = 1'b0;
    chk("midrst_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'({a_done, b_done}), 32'd0);
    cyc(); cyc();
    chk("midrst_nodone", 32'({a_done, b_done}), 32'd0);
    rdy_mode = 0;
    issue(1, 0, 8'h09, 8'h3C, 8'h00, 8'h00);
    wait_idle("after_rst");

    // Randomized traffic with random ready and occasional mid-frame input changes
    for (int k = 0; k < 40; k++) begin
      rsel = $urandom_range(1, 3);
      rdy_mode = $urandom_range(0, 1);
      t0 = 8'($urandom); p0 = 8'($urandom);
      t1 = 8'($urandom); p1 = 8'($urandom);
      issue(rsel[0], rsel[1], t0, p0, t1, p1);
      if (rsel != 3 && $urandom_range(0, 1) == 1) begin
        cyc();
        if (rsel == 1) begin a_typ = 8'($urandom); a_pay = 8'($urandom); end
        else begin b_typ = 8'($urandom); b_pay = 8'($urandom); end
      end
      wait_idle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
